// File: rtl/mips_dmem_arbiter_if.sv
// Data-memory port bundle shared by the CPU M stage, a DMA requester and the
// data RAM. The arbiter takes the slave view; whatever drives the CPU/DMA/RAM
// side (a top level or a bench) takes the master view.
interface mips_dmem_arbiter_if #(
    parameter int AW = 32
);
    logic          en_in;
    logic          cpu_en;
    logic          cpu_re;
    logic [3:0]    cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_wdata;
    logic [31:0]   cpu_rdata;
    logic          dma_req;
    logic [3:0]    dma_we;
    logic [AW-1:0] dma_addr;
    logic [31:0]   dma_wdata;
    logic          dma_gnt;
    logic [31:0]   dma_rdata;
    logic          dma_rvalid;
    logic          mem_re;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport slave (
        input  en_in, cpu_re, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_en, cpu_rdata, dma_gnt, dma_rdata, dma_rvalid,
        output mem_re, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output en_in, cpu_re, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_en, cpu_rdata, dma_gnt, dma_rdata, dma_rvalid,
        input  mem_re, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mips_dmem_arbiter.sv
// Shares one synchronous data-memory port between the CPU M stage and a DMA
// requester. The CPU wins by default; a DMA requester starved for MAX_WAIT
// cycles triggers a forced window in which the CPU is frozen for up to
// BURST_LEN DMA beats. A CPU load whose data returns while the CPU is frozen
// is held so the M stage still sees it when it resumes.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_CPU   | CPU owns the port; DMA only gets cycles the CPU leaves idle
//   ST_STALL | CPU frozen (cpu_en=0); every DMA request is granted
module mips_dmem_arbiter #(
    parameter int MAX_WAIT  = 4,
    parameter int BURST_LEN = 4,
    parameter int AW        = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    mips_dmem_arbiter_if.slave   bus
);
    localparam int WW = (MAX_WAIT  < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam int BW = (BURST_LEN < 1) ? 1 : $clog2(BURST_LEN + 1);

    typedef enum logic {
        ST_CPU   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [WW-1:0] wait_cnt, wait_nxt;
    logic [BW-1:0] beat_cnt, beat_nxt;

    logic          cpu_en;
    logic          cpu_req;
    logic          dma_gnt;
    logic          dma_rd;
    logic          dma_starved;

    logic          mem_re;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;

    logic          dma_rvalid;
    logic          cpu_rd_pend;
    logic          hold_valid;
    logic [31:0]   hold;

    // Grant decision and port mux; DMA wins whenever the enabled CPU is idle.
    always_comb begin
        cpu_en      = bus.en_in & (state == ST_CPU);
        cpu_req     = (bus.cpu_re | (|bus.cpu_we)) & cpu_en;
        dma_gnt     = bus.dma_req & ~cpu_req;
        dma_rd      = (bus.dma_we == 4'b0000);
        dma_starved = bus.dma_req & ~dma_gnt;
        if (dma_gnt) begin
            mem_re    = dma_rd;
            mem_we    = bus.dma_we;
            mem_addr  = bus.dma_addr;
            mem_wdata = bus.dma_wdata;
        end else begin
            mem_re    = bus.cpu_re & cpu_en;
            mem_we    = cpu_en ? bus.cpu_we : 4'b0000;
            mem_addr  = bus.cpu_addr;
            mem_wdata = bus.cpu_wdata;
        end
    end

    // Next state plus starvation and burst counters.
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        beat_nxt  = beat_cnt;
        case (state)
            ST_CPU: begin
                beat_nxt = '0;
                if (dma_starved) begin
                    if (wait_cnt == WW'(MAX_WAIT)) begin
                        state_nxt = ST_STALL;
                    end else begin
                        wait_nxt = wait_cnt + WW'(1);
                    end
                end else begin
                    wait_nxt = '0;
                end
            end
            ST_STALL: begin
                wait_nxt = '0;
                if (dma_gnt) begin
                    beat_nxt = beat_cnt + BW'(1);
                end
                if ((dma_gnt && beat_cnt == BW'(BURST_LEN - 1)) || !bus.dma_req) begin
                    state_nxt = ST_CPU;
                    beat_nxt  = '0;
                end
            end
            default: begin
                state_nxt = ST_CPU;
                wait_nxt  = '0;
                beat_nxt  = '0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_CPU;
            wait_cnt <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            beat_cnt <= beat_nxt;
        end
    end

    // Read-return tracking and the CPU load-data hold across a freeze.
    always_ff @(posedge clk) begin
        if (rst) begin
            dma_rvalid  <= 1'b0;
            cpu_rd_pend <= 1'b0;
            hold_valid  <= 1'b0;
            hold        <= '0;
        end else begin
            dma_rvalid  <= dma_gnt & dma_rd;
            cpu_rd_pend <= ~dma_gnt & bus.cpu_re & cpu_en;
            if (cpu_en) begin
                hold_valid <= 1'b0;
            end else if (cpu_rd_pend) begin
                hold       <= bus.mem_rdata;
                hold_valid <= 1'b1;
            end
        end
    end

    assign bus.cpu_en     = cpu_en;
    assign bus.cpu_rdata  = hold_valid ? hold : bus.mem_rdata;
    assign bus.dma_gnt    = dma_gnt;
    assign bus.dma_rdata  = bus.mem_rdata;
    assign bus.dma_rvalid = dma_rvalid;
    assign bus.mem_re     = mem_re;
    assign bus.mem_we     = mem_we;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_wdata  = mem_wdata;
endmodule

// File: tb/tb_mips_dmem_arbiter.sv
// Bench for mips_dmem_arbiter: two instances (BURST_LEN 2 and 4, MAX_WAIT 4)
// share stimulus, each with its own 1-cycle-latency RAM model.
module tb_mips_dmem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mips_dmem_arbiter_if #(.AW(32)) bus2 ();
    mips_dmem_arbiter_if #(.AW(32)) bus4 ();

    mips_dmem_arbiter #(.MAX_WAIT(4), .BURST_LEN(2), .AW(32)) dut2 (
        .clk (clk), .rst (rst), .bus (bus2.slave)
    );
    mips_dmem_arbiter #(.MAX_WAIT(4), .BURST_LEN(4), .AW(32)) dut4 (
        .clk (clk), .rst (rst), .bus (bus4.slave)
    );

    assign bus4.en_in     = bus2.en_in;
    assign bus4.cpu_re    = bus2.cpu_re;
    assign bus4.cpu_we    = bus2.cpu_we;
    assign bus4.cpu_addr  = bus2.cpu_addr;
    assign bus4.cpu_wdata = bus2.cpu_wdata;
    assign bus4.dma_req   = bus2.dma_req;
    assign bus4.dma_we    = bus2.dma_we;
    assign bus4.dma_addr  = bus2.dma_addr;
    assign bus4.dma_wdata = bus2.dma_wdata;

    logic [31:0] ram2 [0:255];
    logic [31:0] ram4 [0:255];
    logic [31:0] q2, q4;
    assign bus2.mem_rdata = q2;
    assign bus4.mem_rdata = q4;

    // RAM models: contents re-seeded on every reset.
    always @(posedge clk) begin
        if (bus2.mem_re) q2 <= ram2[bus2.mem_addr[9:2]];
        if (rst) begin
            for (int i = 0; i < 256; i++) ram2[i] <= 32'h5000_0000 + 32'(i);
            ram2[16] <= 32'h1111_0040;
            ram2[64] <= 32'hDEAD_BEEF;
        end else begin
            for (int b = 0; b < 4; b++)
                if (bus2.mem_we[b]) ram2[bus2.mem_addr[9:2]][8*b +: 8] <= bus2.mem_wdata[8*b +: 8];
        end
    end

    always @(posedge clk) begin
        if (bus4.mem_re) q4 <= ram4[bus4.mem_addr[9:2]];
        if (rst) begin
            for (int i = 0; i < 256; i++) ram4[i] <= 32'h5000_0000 + 32'(i);
            ram4[16] <= 32'h1111_0040;
            ram4[64] <= 32'hDEAD_BEEF;
        end else begin
            for (int b = 0; b < 4; b++)
                if (bus4.mem_we[b]) ram4[bus4.mem_addr[9:2]][8*b +: 8] <= bus4.mem_wdata[8*b +: 8];
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive(input logic en, input logic re, input logic [3:0] cwe,
                         input logic [31:0] ca, input logic [31:0] cd,
                         input logic dq, input logic [3:0] dwe,
                         input logic [31:0] da, input logic [31:0] dd);
        bus2.en_in     = en;
        bus2.cpu_re    = re;
        bus2.cpu_we    = cwe;
        bus2.cpu_addr  = ca;
        bus2.cpu_wdata = cd;
        bus2.dma_req   = dq;
        bus2.dma_we    = dwe;
        bus2.dma_addr  = da;
        bus2.dma_wdata = dd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    typedef struct {
        logic        en_in;
        logic        cpu_re;
        logic [3:0]  cpu_we;
        logic [31:0] cpu_addr;
        logic [31:0] cpu_wdata;
        logic        dma_req;
        logic [3:0]  dma_we;
        logic [31:0] dma_addr;
        logic [31:0] dma_wdata;
        logic        e_cpu_en;
        logic        e_gnt;
        logic        e_re;
        logic [3:0]  e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t vt [7];

    initial begin
        vt[0] = '{1'b1, 1'b0, 4'h0, 32'h10, 32'h0,         1'b0, 4'h0, 32'h0,  32'h0,
                  1'b1, 1'b0, 1'b0, 4'h0, 32'h10, 32'h0};
        vt[1] = '{1'b1, 1'b1, 4'h0, 32'h20, 32'h0,         1'b1, 4'h0, 32'h44, 32'h0,
                  1'b1, 1'b0, 1'b1, 4'h0, 32'h20, 32'h0};
        vt[2] = '{1'b1, 1'b0, 4'h3, 32'h24, 32'h1234_5678, 1'b1, 4'hF, 32'h48, 32'h9999_9999,
                  1'b1, 1'b0, 1'b0, 4'h3, 32'h24, 32'h1234_5678};
        vt[3] = '{1'b1, 1'b0, 4'h0, 32'h28, 32'h7777_7777, 1'b1, 4'hC, 32'h48, 32'hCAFE_0000,
                  1'b1, 1'b1, 1'b0, 4'hC, 32'h48, 32'hCAFE_0000};
        vt[4] = '{1'b1, 1'b0, 4'h0, 32'h2C, 32'h0,         1'b1, 4'h0, 32'h4C, 32'h0,
                  1'b1, 1'b1, 1'b1, 4'h0, 32'h4C, 32'h0};
        vt[5] = '{1'b0, 1'b1, 4'h0, 32'h30, 32'h0,         1'b1, 4'h0, 32'h50, 32'h0,
                  1'b0, 1'b1, 1'b1, 4'h0, 32'h50, 32'h0};
        vt[6] = '{1'b0, 1'b0, 4'hF, 32'h34, 32'h3333_3333, 1'b0, 4'h0, 32'h0,  32'h0,
                  1'b0, 1'b0, 1'b0, 4'h0, 32'h34, 32'h3333_3333};

        drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("rst.cpu_en", 32'(bus2.cpu_en), 32'd1);
        chk("rst.gnt", 32'(bus2.dma_gnt), 32'd0);
        chk("rst.rvalid", 32'(bus2.dma_rvalid), 32'd0);
        chk("rst.mem_re", 32'(bus2.mem_re), 32'd0);
        chk("rst.mem_we", 32'(bus2.mem_we), 32'd0);
        next_cycle();

        // Single-cycle decode vectors, each from a fresh reset.
        for (int i = 0; i < 7; i++) begin
            do_reset();
            drive(vt[i].en_in, vt[i].cpu_re, vt[i].cpu_we, vt[i].cpu_addr, vt[i].cpu_wdata,
                  vt[i].dma_req, vt[i].dma_we, vt[i].dma_addr, vt[i].dma_wdata);
            @(negedge clk);
            chk($sformatf("vec%0d.cpu_en", i), 32'(bus2.cpu_en), 32'(vt[i].e_cpu_en));
            chk($sformatf("vec%0d.gnt", i), 32'(bus2.dma_gnt), 32'(vt[i].e_gnt));
            chk($sformatf("vec%0d.mem_re", i), 32'(bus2.mem_re), 32'(vt[i].e_re));
            chk($sformatf("vec%0d.mem_we", i), 32'(bus2.mem_we), 32'(vt[i].e_we));
            chk($sformatf("vec%0d.mem_addr", i), bus2.mem_addr, vt[i].e_addr);
            chk($sformatf("vec%0d.mem_wdata", i), bus2.mem_wdata, vt[i].e_wdata);
            next_cycle();
        end

        // Idle CPU: DMA read granted at once, data the next cycle.
        do_reset();
        drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h40, 32'h0);
        @(negedge clk);
        chk("t1.gnt", 32'(bus2.dma_gnt), 32'd1);
        chk("t1.mem_addr", bus2.mem_addr, 32'h40);
        next_cycle();
        drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("t1.rvalid", 32'(bus2.dma_rvalid), 32'd1);
        chk("t1.rdata", bus2.dma_rdata, 32'h1111_0040);
        next_cycle();
        @(negedge clk);
        chk("t1.rvalid_drop", 32'(bus2.dma_rvalid), 32'd0);
        next_cycle();

        // Busy CPU: cycles 1-5 starved (wait_cnt 0..4), cycles 6-7 forced window, 8 CPU again.
        do_reset();
        for (int c = 1; c <= 8; c++) begin
            drive(1'b1, 1'b1, 4'h0, 32'h200, 32'h0, 1'b1, 4'h0, 32'h60, 32'h0);
            @(negedge clk);
            chk($sformatf("t2.c%0d.cpu_en", c), 32'(bus2.cpu_en), (c == 6 || c == 7) ? 32'd0 : 32'd1);
            chk($sformatf("t2.c%0d.gnt", c), 32'(bus2.dma_gnt), (c == 6 || c == 7) ? 32'd1 : 32'd0);
            next_cycle();
        end

        // CPU load issued in the cycle that enters the window survives DMA reads.
        do_reset();
        for (int c = 1; c <= 7; c++) begin
            drive(1'b1, 1'b1, 4'h0, (c >= 5) ? 32'h100 : 32'h200, 32'h0, 1'b1, 4'h0, 32'h40, 32'h0);
            @(negedge clk);
            if (c == 6) chk("t3.c6.cpu_en", 32'(bus2.cpu_en), 32'd0);
            if (c == 7) begin
                chk("t3.c7.cpu_en", 32'(bus2.cpu_en), 32'd0);
                chk("t3.c7.rvalid", 32'(bus2.dma_rvalid), 32'd1);
                chk("t3.c7.dma_rdata", bus2.dma_rdata, 32'h1111_0040);
            end
            next_cycle();
        end
        drive(1'b1, 1'b1, 4'h0, 32'h100, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("t3.resume.cpu_en", 32'(bus2.cpu_en), 32'd1);
        chk("t3.resume.cpu_rdata", bus2.cpu_rdata, 32'hDEAD_BEEF);
        next_cycle();

        // BURST_LEN=4 window cut short when the DMA request drops after one beat.
        do_reset();
        for (int c = 1; c <= 13; c++) begin
            drive(1'b1, 1'b1, 4'h0, 32'h200, 32'h0, (c != 7), 4'h0, 32'h60, 32'h0);
            @(negedge clk);
            if (c == 6) begin
                chk("t4.c6.cpu_en", 32'(bus4.cpu_en), 32'd0);
                chk("t4.c6.gnt", 32'(bus4.dma_gnt), 32'd1);
            end
            if (c == 7) chk("t4.c7.gnt", 32'(bus4.dma_gnt), 32'd0);
            if (c == 8) chk("t4.c8.cpu_en", 32'(bus4.cpu_en), 32'd1);
            if (c == 12) chk("t4.c12.cpu_en", 32'(bus4.cpu_en), 32'd1);
            if (c == 13) chk("t4.c13.cpu_en", 32'(bus4.cpu_en), 32'd0);
            next_cycle();
        end

        // Reset inside the forced window discards rvalid and the pending hold.
        do_reset();
        for (int c = 1; c <= 6; c++) begin
            drive(1'b1, 1'b1, 4'h0, (c >= 5) ? 32'h100 : 32'h200, 32'h0, 1'b1, 4'h0, 32'h40, 32'h0);
            if (c == 6) rst = 1'b1;
            @(negedge clk);
            if (c == 6) chk("t5.c6.cpu_en", 32'(bus2.cpu_en), 32'd0);
            next_cycle();
        end
        rst = 1'b0;
        drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("t5.cpu_en", 32'(bus2.cpu_en), 32'd1);
        chk("t5.rvalid", 32'(bus2.dma_rvalid), 32'd0);
        chk("t5.cpu_rdata", bus2.cpu_rdata, 32'h1111_0040);
        next_cycle();

        // en_in low: DMA write goes through, CPU write never reaches the RAM.
        do_reset();
        drive(1'b0, 1'b0, 4'hF, 32'h84, 32'hFFFF_FFFF, 1'b1, 4'hF, 32'h80, 32'hA5A5_A5A5);
        @(negedge clk);
        chk("t6.cpu_en", 32'(bus2.cpu_en), 32'd0);
        chk("t6.gnt", 32'(bus2.dma_gnt), 32'd1);
        chk("t6.mem_we", 32'(bus2.mem_we), 32'hF);
        chk("t6.mem_addr", bus2.mem_addr, 32'h80);
        chk("t6.mem_wdata", bus2.mem_wdata, 32'hA5A5_A5A5);
        next_cycle();
        drive(1'b0, 1'b0, 4'hF, 32'h84, 32'hFFFF_FFFF, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("t6.idle.mem_we", 32'(bus2.mem_we), 32'd0);
        chk("t6.idle.gnt", 32'(bus2.dma_gnt), 32'd0);
        next_cycle();
        drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("t6.ram80", ram2[32], 32'hA5A5_A5A5);
        chk("t6.ram84", ram2[33], 32'h5000_0021);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
